// File: rtl/alu8_pkg.sv
// Shared types for the alu8 command issuer: opcode encodings, the queued
// command record and the issuer FSM state.
package alu8_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDC = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SUBB = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    // Only the lower half of the opcode space maps to an ALU unit.
    function automatic logic op_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu8_cmd_issuer_if.sv
// Bus bundle around the issuer: command channel in, result channel out, and
// the operand/opcode/result wires to the alu8 responder.
interface alu8_cmd_issuer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_out;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;
    logic [7:0] acc_out;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_out,
        output res_valid, res_data, res_err, acc_out,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_out,
        input  res_valid, res_data, res_err, acc_out,
        output res_ready
    );

endinterface

// File: rtl/alu8_cmd_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy counter; pushes
// are refused while full regardless of a same-cycle pop.
module alu8_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= (AW+1)'(r_count + 1'b1);
                2'b01:   r_count <= (AW+1)'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu8_cmd_issuer.sv
// Queues ALU commands, issues them one at a time to the alu8 responder and
// returns each captured result over a valid/ready channel.
module alu8_cmd_issuer
    import alu8_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu8_cmd_issuer_if.master  bus
);

    cmd_t   w_wcmd;
    cmd_t   w_head;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_empty;
    state_e w_state_d;

    state_e     r_state;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [3:0] r_alu_opcode;
    logic       r_illegal;
    logic [7:0] r_res_data;
    logic       r_res_err;
    logic [7:0] r_acc;

    assign w_wcmd = '{opcode:  bus.cmd_opcode,
                      a:       bus.cmd_a,
                      b:       bus.cmd_b,
                      use_acc: bus.cmd_use_acc};
    assign w_push = bus.cmd_valid && !w_full;

    alu8_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wcmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                w_state_d = StResp;
            end
            StResp: begin
                if (bus.res_ready) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StIssue;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_illegal    <= 1'b0;
            r_res_data   <= '0;
            r_res_err    <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_state <= w_state_d;
            // The accumulator was written in the preceding ISSUE cycle, so a
            // chained use_acc command always sees the previous result here.
            if (w_pop) begin
                r_alu_a      <= w_head.use_acc ? r_acc : w_head.a;
                r_alu_b      <= w_head.b;
                r_alu_opcode <= w_head.opcode;
                r_illegal    <= op_illegal(w_head.opcode);
            end
            if (r_state == StIssue) begin
                if (r_illegal) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end else begin
                    r_res_data <= bus.alu_out;
                    r_res_err  <= 1'b0;
                    r_acc      <= bus.alu_out;
                end
            end
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.res_valid  = (r_state == StResp);
    assign bus.res_data   = r_res_data;
    assign bus.res_err    = r_res_err;
    assign bus.acc_out    = r_acc;

endmodule

// File: tb/tb_alu8_cmd_issuer.sv
// Directed bench for alu8_cmd_issuer with a behavioural alu8 responder.
module tb_alu8_cmd_issuer;
    import alu8_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu8_cmd_issuer_if bus ();

    alu8_cmd_issuer #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder model; illegal opcodes return junk the issuer must not forward.
    always_comb begin
        case (bus.alu_opcode)
            OP_ADD:  bus.alu_out = bus.alu_a + bus.alu_b;
            OP_ADDC: bus.alu_out = bus.alu_a + bus.alu_b + 8'd1;
            OP_SUB:  bus.alu_out = bus.alu_a - bus.alu_b;
            OP_SUBB: bus.alu_out = bus.alu_a - bus.alu_b - 8'd1;
            OP_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_out = bus.alu_a | bus.alu_b;
            OP_SHL:  bus.alu_out = {bus.alu_a[6:0], 1'b0};
            OP_SHR:  bus.alu_out = {1'b0, bus.alu_a[7:1]};
            default: bus.alu_out = 8'hA5;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ua;
        logic [7:0] exp_alu_a;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua);
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = ua;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int k;
        k = 0;
        while (!bus.res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, bus.res_valid}, 32'd1);
    endtask

    task automatic ack();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] got [$];
        int         got_cyc [$];
        int         nvalid;
        logic [7:0] bp_exp;

        n_checks = 0;
        n_fail   = 0;

        //               op     a      b      ua    alu_a  data   err   acc
        vecs[0]  = '{4'b0001, 8'h0F, 8'h01, 1'b0, 8'h0F, 8'h11, 1'b0, 8'h11};
        vecs[1]  = '{4'b0010, 8'h33, 8'h12, 1'b1, 8'h11, 8'hFF, 1'b0, 8'hFF};
        vecs[2]  = '{4'b1010, 8'h55, 8'hAA, 1'b0, 8'h55, 8'h00, 1'b1, 8'hFF};
        vecs[3]  = '{4'b0110, 8'h81, 8'h00, 1'b0, 8'h81, 8'h02, 1'b0, 8'h02};
        vecs[4]  = '{4'b0111, 8'h81, 8'h00, 1'b0, 8'h81, 8'h40, 1'b0, 8'h40};
        vecs[5]  = '{4'b0101, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'hFF, 1'b0, 8'hFF};
        vecs[6]  = '{4'b0100, 8'hF0, 8'h3C, 1'b0, 8'hF0, 8'h30, 1'b0, 8'h30};
        vecs[7]  = '{4'b0011, 8'h10, 8'h01, 1'b0, 8'h10, 8'h0E, 1'b0, 8'h0E};
        vecs[8]  = '{4'b0000, 8'h77, 8'hF5, 1'b1, 8'h0E, 8'h03, 1'b0, 8'h03};
        vecs[9]  = '{4'b1111, 8'h12, 8'h34, 1'b0, 8'h12, 8'h00, 1'b1, 8'h03};
        vecs[10] = '{4'b0110, 8'h99, 8'h00, 1'b1, 8'h03, 8'h06, 1'b0, 8'h06};
        vecs[11] = '{4'b0001, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00};

        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.res_ready   = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_res_data", {24'd0, bus.res_data}, 32'h00);
        check("rst_res_err", {31'd0, bus.res_err}, 32'd0);
        check("rst_acc", {24'd0, bus.acc_out}, 32'h00);
        check("rst_alu", {12'd0, bus.alu_opcode, bus.alu_a, bus.alu_b}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // First command latency: operands one cycle after the push, result one later.
        push(OP_ADD, 8'h0F, 8'h01, 1'b0);
        check("lat_alu_a_before", {24'd0, bus.alu_a}, 32'h00);
        check("lat_valid_t0", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        check("lat_alu_a", {24'd0, bus.alu_a}, 32'h0F);
        check("lat_alu_b", {24'd0, bus.alu_b}, 32'h01);
        check("lat_alu_op", {28'd0, bus.alu_opcode}, 32'h0);
        check("lat_valid_t1", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid_t2", {31'd0, bus.res_valid}, 32'd1);
        check("lat_data", {24'd0, bus.res_data}, 32'h10);
        check("lat_err", {31'd0, bus.res_err}, 32'd0);
        check("lat_acc", {24'd0, bus.acc_out}, 32'h10);
        @(negedge clk);
        check("lat_hold_valid", {31'd0, bus.res_valid}, 32'd1);
        check("lat_hold_data", {24'd0, bus.res_data}, 32'h10);
        ack();
        check("lat_idle_valid", {31'd0, bus.res_valid}, 32'd0);
        check("lat_alu_a_hold", {24'd0, bus.alu_a}, 32'h0F);

        for (int i = 0; i < 12; i++) begin
            push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua);
            wait_res($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_alu_a", i), {24'd0, bus.alu_a}, {24'd0, vecs[i].exp_alu_a});
            check($sformatf("vec%0d_data", i), {24'd0, bus.res_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_err", i), {31'd0, bus.res_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_acc", i), {24'd0, bus.acc_out}, {24'd0, vecs[i].exp_acc});
            ack();
        end

        // Backpressure: one in flight plus four buffered fills the FIFO.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_ready%0d", i), {31'd0, bus.cmd_ready}, 32'd1);
            push(OP_ADD, 8'(i + 1), 8'(i + 1), 1'b0);
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = OP_ADD;
        bus.cmd_a       = 8'h77;
        bus.cmd_b       = 8'h77;
        bus.cmd_use_acc = 1'b0;
        check("bp_full", {31'd0, bus.cmd_ready}, 32'd0);
        check("bp_valid", {31'd0, bus.res_valid}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_stable_data", {24'd0, bus.res_data}, 32'h02);
            check("bp_stable_full", {31'd0, bus.cmd_ready}, 32'd0);
        end
        // The pop on this edge must not let the held sixth command in.
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("bp_ready_after_pop", {31'd0, bus.cmd_ready}, 32'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                got.push_back(bus.res_data);
                got_cyc.push_back(c);
            end
        end
        bus.res_ready = 1'b0;
        check("bp_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            bp_exp = 8'(2 * (i + 2));
            if (i < got.size()) begin
                check($sformatf("bp_res%0d", i), {24'd0, got[i]}, {24'd0, bp_exp});
                check($sformatf("bp_cyc%0d", i), got_cyc[i], 32'(2 * i + 1));
            end
        end
        check("bp_acc", {24'd0, bus.acc_out}, 32'h0A);

        // Reset while a result is pending and two commands are queued.
        push(OP_ADD, 8'h20, 8'h20, 1'b0);
        push(OP_SUB, 8'h05, 8'h01, 1'b0);
        push(OP_ADD, 8'h01, 8'h01, 1'b0);
        wait_res("mid_valid");
        check("mid_data", {24'd0, bus.res_data}, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("mid_rst_acc", {24'd0, bus.acc_out}, 32'h00);
        check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mid_rst_data", {24'd0, bus.res_data}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.res_valid) nvalid++;
        end
        bus.res_ready = 1'b0;
        check("mid_no_stale", nvalid, 32'd0);
        check("mid_alu_a", {24'd0, bus.alu_a}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
